uart_level_ctrl: RTL and testbench

//  Frame controller between the UART receiver and the VU-meter display logic.
//  - Consumes received bytes and parses 4-byte level frames: SYNC, CH, LEVEL, CSUM.
//  - On a valid frame, updates the per-channel level register.
//  - Counts framing/checksum/timeout errors.
//  - rx_valid is a single-cycle pulse, already synchronised into the clk domain upstream.

---
 rtl/uart_level_ctrl_if.sv | 24 ++
 rtl/uart_level_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_level_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_level_ctrl_if.sv
// Byte-stream and level/status bundle between the UART receiver side and
// the level frame controller.
interface uart_level_ctrl_if #(
  parameter int NUM_CH = 2
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                err_clr;
  logic [NUM_CH*8-1:0] level_out;
  logic [NUM_CH-1:0]   level_upd;
  logic                frame_err;
  logic [7:0]          err_cnt;
  logic                busy;

  modport master (
    output rx_data, rx_valid, err_clr,
    input  level_out, level_upd, frame_err, err_cnt, busy
  );

  modport slave (
    input  rx_data, rx_valid, err_clr,
    output level_out, level_upd, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_level_ctrl.sv
// Parses SYNC/CH/LEVEL/CSUM frames from a received byte stream, updates
// per-channel level registers and counts rejected or timed-out frames.
module uart_level_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         NUM_CH      = 2,
  parameter int         TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  uart_level_ctrl_if.slave  bus
);

  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      CH_LIM  = 8'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_CH, S_LVL, S_CSUM} state_t;

  state_t          state_q, state_d;
  logic [7:0]      ch_q;
  logic [7:0]      lvl_q;
  logic [7:0]      csum_q;
  logic [TW-1:0]   to_q;
  logic [7:0]      level_q [NUM_CH];
  logic [NUM_CH-1:0] upd_q;
  logic            ferr_q;
  logic [7:0]      errcnt_q;

  logic frame_ok;
  logic frame_bad;
  logic timeout;
  logic err_event;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state; a strobe always takes priority over timeout expiry
  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: if (bus.rx_data == SYNC_BYTE) state_d = S_CH;
        S_CH:   state_d = S_LVL;
        S_LVL:  state_d = S_CSUM;
        S_CSUM: begin
          if ((bus.rx_data == csum_q) && (ch_q < CH_LIM)) frame_ok  = 1'b1;
          else                                           frame_bad = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (to_q == TO_LAST)) begin
      timeout = 1'b1;
      state_d = S_IDLE;
    end
  end

  // Outputs
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.frame_err = ferr_q;
    bus.err_cnt   = errcnt_q;
    bus.level_upd = upd_q;
  end

  assign err_event = frame_bad | timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q   <= '0;
      lvl_q  <= '0;
      csum_q <= '0;
      to_q   <= '0;
    end else begin
      if (bus.rx_valid || state_q == S_IDLE) to_q <= '0;
      else                                   to_q <= to_q + 1'b1;
      if (bus.rx_valid) begin
        case (state_q)
          S_IDLE: csum_q <= SYNC_BYTE;
          S_CH: begin
            ch_q   <= bus.rx_data;
            csum_q <= csum_q ^ bus.rx_data;
          end
          S_LVL: begin
            lvl_q  <= bus.rx_data;
            csum_q <= csum_q ^ bus.rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Clear wins over a simultaneous error; the pulse is still emitted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      ferr_q <= err_event;
      if (bus.err_clr)                         errcnt_q <= '0;
      else if (err_event && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic hit;
    assign hit = frame_ok && (ch_q == 8'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        level_q[gi] <= '0;
        upd_q[gi]   <= 1'b0;
      end else begin
        upd_q[gi] <= hit;
        if (hit) level_q[gi] <= lvl_q;
      end
    end

    assign bus.level_out[gi*8 +: 8] = level_q[gi];
  end

endmodule

// File: tb/tb_uart_level_ctrl.sv
// Directed frames against a byte-level frame model, compared every cycle,
// plus literal expectations at key points.
module tb_uart_level_ctrl;
  localparam int NCH = 2;
  localparam int TO  = 20000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_level_ctrl_if #(.NUM_CH(NCH)) bus ();

  uart_level_ctrl #(
    .SYNC_BYTE  (8'hA5),
    .NUM_CH     (NCH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: counts bytes collected in the current frame and cycles since the last one
  logic [7:0]     m_level [NCH];
  logic [NCH-1:0] m_upd;
  logic           m_ferr;
  int             m_cnt;
  int             m_n;
  int             m_idle;
  logic [7:0]     m_ch, m_lvl;

  always @(posedge clk) begin
    automatic logic err = 1'b0;
    automatic logic [NCH*8-1:0] exp_level;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) m_level[c] = 8'h00;
      m_upd = '0; m_ferr = 1'b0; m_cnt = 0; m_n = 0; m_idle = 0;
    end else begin
      m_upd = '0;
      if (bus.rx_valid) begin
        m_idle = 0;
        case (m_n)
          0: if (bus.rx_data == 8'hA5) m_n = 1;
          1: begin m_ch = bus.rx_data; m_n = 2; end
          2: begin m_lvl = bus.rx_data; m_n = 3; end
          default: begin
            if (bus.rx_data == (8'hA5 ^ m_ch ^ m_lvl) && int'(m_ch) < NCH) begin
              m_level[m_ch] = m_lvl;
              m_upd[m_ch]   = 1'b1;
            end else err = 1'b1;
            m_n = 0;
          end
        endcase
      end else if (m_n != 0) begin
        m_idle++;
        if (m_idle >= TO) begin err = 1'b1; m_n = 0; m_idle = 0; end
      end
      m_ferr = err;
      if (bus.err_clr)           m_cnt = 0;
      else if (err && m_cnt < 255) m_cnt++;
    end
    for (int c = 0; c < NCH; c++) exp_level[c*8 +: 8] = m_level[c];
    #1;
    chk("m_level_out", 32'(bus.level_out), 32'(exp_level));
    chk("m_level_upd", 32'(bus.level_upd), 32'(m_upd));
    chk("m_frame_err", 32'(bus.frame_err), 32'(m_ferr));
    chk("m_err_cnt",   32'(bus.err_cnt),   32'(m_cnt));
    chk("m_busy",      32'(bus.busy),      32'(m_n != 0));
  end

  // Caller sits on a negedge; the byte is consumed at the following posedge
  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    $display("byte %h level=%h upd=%b ferr=%b cnt=%0d busy=%b",
             b, bus.level_out, bus.level_upd, bus.frame_err, bus.err_cnt, bus.busy);
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    put(a); put(b); put(c); put(d);
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.err_clr  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(bus.level_out), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_cnt",   32'(bus.err_cnt), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    frame(8'hA5, 8'h00, 8'h7F, 8'hDA); idle();
    chk("t1_upd", 32'(bus.level_upd), 32'h1);
    chk("t1_level", 32'(bus.level_out), 32'h007F);
    chk("t1_cnt", 32'(bus.err_cnt), 32'h0);
    @(negedge clk);
    chk("t1_upd_gone", 32'(bus.level_upd), 32'h0);

    frame(8'hA5, 8'h01, 8'h40, 8'hE4); idle();
    chk("t2_upd", 32'(bus.level_upd), 32'h2);
    chk("t2_level", 32'(bus.level_out), 32'h407F);

    frame(8'hA5, 8'h00, 8'h7F, 8'hDB); idle();
    chk("t3_ferr", 32'(bus.frame_err), 32'h1);
    chk("t3_cnt", 32'(bus.err_cnt), 32'h1);
    chk("t3_level", 32'(bus.level_out), 32'h407F);

    frame(8'hA5, 8'h05, 8'h10, 8'hB0); idle();
    chk("t4_ferr", 32'(bus.frame_err), 32'h1);
    chk("t4_cnt", 32'(bus.err_cnt), 32'h2);
    chk("t4_upd", 32'(bus.level_upd), 32'h0);

    frame(8'hA5, 8'h00, 8'hA5, 8'h00); idle();
    chk("sync_data_level", 32'(bus.level_out), 32'h40A5);

    put(8'h11); put(8'h22);
    frame(8'hA5, 8'h00, 8'h7F, 8'hDA); idle();
    chk("t6_upd", 32'(bus.level_upd), 32'h1);
    chk("t6_cnt", 32'(bus.err_cnt), 32'h2);

    frame(8'hA5, 8'h00, 8'h11, 8'hB4);
    chk("b2b_upd0", 32'(bus.level_upd), 32'h1);
    frame(8'hA5, 8'h01, 8'h22, 8'h86); idle();
    chk("b2b_level", 32'(bus.level_out), 32'h2211);

    put(8'hA5); put(8'h00); idle();
    repeat (TO - 1) @(negedge clk);
    chk("t5_busy_before", 32'(bus.busy), 32'h1);
    chk("t5_ferr_before", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    chk("t5_ferr", 32'(bus.frame_err), 32'h1);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_cnt", 32'(bus.err_cnt), 32'h3);
    frame(8'hA5, 8'h00, 8'h20, 8'h85); idle();
    chk("t5_level", 32'(bus.level_out), 32'h2220);

    put(8'hA5); put(8'h01); idle();
    repeat (TO - 1) @(negedge clk);
    put(8'h33);
    chk("edge_ferr", 32'(bus.frame_err), 32'h0);
    chk("edge_busy", 32'(bus.busy), 32'h1);
    put(8'h97); idle();
    chk("edge_level", 32'(bus.level_out), 32'h3320);
    chk("edge_cnt", 32'(bus.err_cnt), 32'h3);

    for (int i = 0; i < 300; i++) frame(8'hA5, 8'h00, 8'h7F, 8'hDB);
    idle();
    chk("sat_cnt", 32'(bus.err_cnt), 32'hFF);
    put(8'hA5); put(8'h00); put(8'h7F);
    bus.err_clr = 1'b1;
    put(8'hDB); idle();
    bus.err_clr = 1'b0;
    chk("clr_cnt", 32'(bus.err_cnt), 32'h0);
    chk("clr_ferr", 32'(bus.frame_err), 32'h1);
    frame(8'hA5, 8'h00, 8'h7F, 8'hDB); idle();
    chk("clr_recount", 32'(bus.err_cnt), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr_plain", 32'(bus.err_cnt), 32'h0);

    put(8'hA5); put(8'h00); idle();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_level", 32'(bus.level_out), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_cnt", 32'(bus.err_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    frame(8'hA5, 8'h01, 8'h40, 8'hE4); idle();
    chk("post_rst_level", 32'(bus.level_out), 32'h4000);
    chk("post_rst_upd", 32'(bus.level_upd), 32'h2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
